serial_add: RTL and testbench

Bit-serial N-bit adder built around one full_add instance and a carry flip-flop.
- Accepts two WIDTH-bit operands and a carry-in on a start strobe.
- Feeds one bit pair per clock, LSB first, into the full adder and collects the sum serially.
- Presents the parallel sum and carry-out with a one-cycle done pulse.
- Smallest-area alternative to a ripple chain of full_add cells.

---
 rtl/serial_add_if.sv | 28 ++
 rtl/serial_add.sv | 162 ++++++++++++++++
 tb/tb_serial_add.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/serial_add_if.sv
// serial_add_if: operand/result bundle for the bit-serial adder.
//   master: drives start, a, b, ci; observes busy, done, s, co (and ovf)
//   slave : the adder side
//   start - request strobe          a, b - WIDTH-bit operands
//   ci    - carry-in                busy - operation in progress
//   done  - one-cycle result pulse  s, co - held sum and carry-out
//   ovf   - signed overflow, present only when SERIAL_ADD_OVF_EN is defined
interface serial_add_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (output start, a, b, ci, input busy, done, s, co, ovf);
    modport slave  (input start, a, b, ci, output busy, done, s, co, ovf);
`else
    modport master (output start, a, b, ci, input busy, done, s, co);
    modport slave  (input start, a, b, ci, output busy, done, s, co);
`endif
endinterface

// File: rtl/serial_add.sv
// serial_add: bit-serial WIDTH-bit adder using a single full_add cell and a
// carry flop. Operands are captured on start, one bit pair is added per clock
// (LSB first), and the parallel sum/carry-out are published with a done pulse.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - serial_add_if.slave (start, a, b, ci, busy, done, s, co[, ovf])
// Optional feature macro: SERIAL_ADD_OVF_EN adds the ovf output (two's-complement
// overflow = carry into MSB XOR carry out of MSB).

module full_add (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_add_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             cmsb_q, cmsb_d;
    logic             ovf_q, ovf_d;
`endif

    logic fa_s, fa_co;
    logic accept;

    full_add u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // New work is taken only when not shifting; DONE accepts for back-to-back use.
    assign accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sr_d    = sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        s_d     = s_q;
        co_d    = co_q;
`ifdef SERIAL_ADD_OVF_EN
        cmsb_d  = cmsb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
                // Sum bits enter at the MSB so that after WIDTH shifts the
                // first (LSB) sum bit has reached bit 0.
                sr_d    = {fa_s, sr_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                    // carry entering the MSB full-add this cycle
                    cmsb_d  = carry_q;
`endif
                end
            end
            ST_DONE: begin
                s_d     = sr_q;
                co_d    = carry_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
`ifdef SERIAL_ADD_OVF_EN
                ovf_d   = cmsb_q ^ carry_q;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            a_d     = bus.a;
            b_d     = bus.b;
            carry_d = bus.ci;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sr_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            cmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sr_q    <= sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            s_q     <= s_d;
            co_q    <= co_d;
`ifdef SERIAL_ADD_OVF_EN
            cmsb_q  <= cmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.co   = co_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add.sv
// tb_serial_add: checks serial_add at WIDTH=8 (vector table, latency, held
// start, mid-operation reset) and at WIDTH=2/8/32 with a random sweep against
// plain integer addition.
module tb_serial_add;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_add_if #(.WIDTH(8))  ifc8 ();
    serial_add_if #(.WIDTH(2))  ifc2 ();
    serial_add_if #(.WIDTH(32)) ifc32 ();

    serial_add #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(ifc8));
    serial_add #(.WIDTH(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(ifc2));
    serial_add #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(ifc32));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        logic       ovf;
    } vec_t;

    vec_t tbl[8];

    // One WIDTH=8 operation with a single-cycle start; reports latency in
    // edges (start edge counted as 1), busy-high cycles and done pulses.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          output int lat, output int busy_cnt, output int done_cnt);
        ifc8.a = a; ifc8.b = b; ifc8.ci = ci; ifc8.start = 1'b1;
        lat = -1; busy_cnt = 0; done_cnt = 0;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk); #1;
            ifc8.start = 1'b0;
            ifc8.a = $urandom; ifc8.b = $urandom; ifc8.ci = 1'($urandom);
            if (ifc8.busy) busy_cnt++;
            if (ifc8.done) begin
                done_cnt++;
                if (lat < 0) lat = n;
            end
        end
    endtask

    initial begin
        int lat, bc, dc, dn;
        logic [7:0]  a8, b8;
        logic [1:0]  a2, b2;
        logic [31:0] a32, b32;
        logic        c8, c2, c32;
        logic [8:0]  e8, r8;
        logic [2:0]  e2, r2;
        logic [32:0] e32, r32;
        logic        g8, g2, g32;
`ifdef SERIAL_ADD_OVF_EN
        logic        o8, eo8;
`endif

        tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[5] = '{8'h40, 8'h20, 1'b0, 8'h60, 1'b0, 1'b0};
        tbl[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};

        ifc8.start = 0;  ifc8.a = 0;  ifc8.b = 0;  ifc8.ci = 0;
        ifc2.start = 0;  ifc2.a = 0;  ifc2.b = 0;  ifc2.ci = 0;
        ifc32.start = 0; ifc32.a = 0; ifc32.b = 0; ifc32.ci = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", ifc8.busy, 0);
        chk("rst_done", ifc8.done, 0);
        chk("rst_s",    ifc8.s, 0);
        chk("rst_co",   ifc8.co, 0);
        chk("rst_s32",  ifc32.s, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // vector table
        for (int i = 0; i < 8; i++) begin
            do_op8(tbl[i].a, tbl[i].b, tbl[i].ci, lat, bc, dc);
            chk($sformatf("tbl%0d_s", i), ifc8.s, tbl[i].s);
            chk($sformatf("tbl%0d_co", i), ifc8.co, tbl[i].co);
            chk($sformatf("tbl%0d_lat", i), lat, 10);
            chk($sformatf("tbl%0d_busy", i), bc, 8);
            chk($sformatf("tbl%0d_ndone", i), dc, 1);
`ifdef SERIAL_ADD_OVF_EN
            chk($sformatf("tbl%0d_ovf", i), ifc8.ovf, tbl[i].ovf);
`endif
        end

        // start held high: result every 9 cycles, mid-SHIFT operand changes ignored
        ifc8.a = 8'h10; ifc8.b = 8'h20; ifc8.ci = 0; ifc8.start = 1'b1;
        dn = 0;
        for (int k = 0; k <= 32; k++) begin
            int nx;
            @(posedge clk); #1;
            if (ifc8.done) begin
                dn++;
                chk("held_done_edge", k, 9 * dn);
                chk("held_s", ifc8.s, 8'h30);
                chk("held_co", ifc8.co, 0);
            end
            nx = k + 1;
            ifc8.a = (nx % 9 >= 2 && nx % 9 <= 6) ? 8'hAA : 8'h10;
            ifc8.start = (nx < 27);
        end
        chk("held_ndone", dn, 3);

        // reset in the middle of SHIFT
        do_op8(8'h12, 8'h34, 1'b0, lat, bc, dc); // leaves s = 0x46
        chk("pre_rst_s", ifc8.s, 8'h46);
        ifc8.a = 8'h12; ifc8.b = 8'h34; ifc8.ci = 0; ifc8.start = 1'b1;
        @(posedge clk); #1;        // accepted
        ifc8.start = 1'b0; ifc8.a = 8'h77; ifc8.b = 8'h99;
        repeat (4) @(posedge clk); // four shifts
        #1;
        chk("inflight_s_hold", ifc8.s, 8'h46);
        chk("inflight_busy", ifc8.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", ifc8.busy, 0);
        chk("midrst_done", ifc8.done, 0);
        chk("midrst_s", ifc8.s, 0);
        chk("midrst_co", ifc8.co, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        dc = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (ifc8.done) dc++;
        end
        chk("midrst_nodone", dc, 0);
        do_op8(8'h01, 8'h02, 1'b0, lat, bc, dc);
        chk("postrst_s", ifc8.s, 8'h03);
        chk("postrst_co", ifc8.co, 0);
        chk("postrst_lat", lat, 10);

        // random sweep across all three widths against plain addition
        for (int it = 0; it < 1000; it++) begin
            a8 = 8'($urandom);  b8 = 8'($urandom);  c8 = 1'($urandom);
            a2 = 2'($urandom);  b2 = 2'($urandom);  c2 = 1'($urandom);
            a32 = $urandom;     b32 = $urandom;     c32 = 1'($urandom);
            e8  = {1'b0, a8} + {1'b0, b8} + 9'(c8);
            e2  = {1'b0, a2} + {1'b0, b2} + 3'(c2);
            e32 = {1'b0, a32} + {1'b0, b32} + 33'(c32);
            ifc8.a = a8;   ifc8.b = b8;   ifc8.ci = c8;   ifc8.start = 1;
            ifc2.a = a2;   ifc2.b = b2;   ifc2.ci = c2;   ifc2.start = 1;
            ifc32.a = a32; ifc32.b = b32; ifc32.ci = c32; ifc32.start = 1;
            g8 = 0; g2 = 0; g32 = 0; r8 = '0; r2 = '0; r32 = '0;
`ifdef SERIAL_ADD_OVF_EN
            o8 = 0;
            // signed overflow: same operand signs, result sign differs
            eo8 = (a8[7] == b8[7]) && (e8[7] != a8[7]);
`endif
            for (int n = 0; n < 40; n++) begin
                @(posedge clk); #1;
                ifc8.start = 0; ifc2.start = 0; ifc32.start = 0;
                if (ifc8.done && !g8) begin
                    g8 = 1; r8 = {ifc8.co, ifc8.s};
`ifdef SERIAL_ADD_OVF_EN
                    o8 = ifc8.ovf;
`endif
                end
                if (ifc2.done && !g2)   begin g2 = 1;  r2 = {ifc2.co, ifc2.s};   end
                if (ifc32.done && !g32) begin g32 = 1; r32 = {ifc32.co, ifc32.s}; end
                if (g8 && g2 && g32) break;
            end
            chk("rnd8_done", g8, 1);
            chk("rnd2_done", g2, 1);
            chk("rnd32_done", g32, 1);
            chk("rnd8_sum", r8, e8);
            chk("rnd2_sum", r2, e2);
            chk("rnd32_sum", r32, e32);
`ifdef SERIAL_ADD_OVF_EN
            chk("rnd8_ovf", o8, eo8);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
